// File: rtl/udp_ingress_arbiter.sv
// Packet-granular round-robin arbiter in front of the UDP SUM/MAX processor.
// An in-order tag FIFO of granted ports routes each processor result back to its source.
module udp_ingress_arbiter #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned PKT_BEATS = 63,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS*DATA_W-1:0] req_data,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS-1:0]        req_last,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [DATA_W-1:0]         proc_data,
  output logic                      proc_valid,
  output logic                      proc_last,
  input  logic                      proc_ready,
  input  logic [DATA_W-1:0]         res_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [N_PORTS-1:0]        rsp_valid,
  input  logic [N_PORTS-1:0]        rsp_ready,
  output logic                      busy,
  output logic                      err_len
);

  localparam int unsigned GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_grant_q;
  logic [6:0]    beat_cnt_q;
  logic [6:0]    beat_cnt_d;
  logic          err_len_q;

  logic [GW-1:0] tag_mem_q [TAG_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] tag_count_q;

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic          tag_empty;
  logic          tag_full;
  logic [GW-1:0] head;
  logic          push;
  logic          pop;
  logic          beat_fire;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      cand = GW'((32'(last_grant_q) + k) % N_PORTS);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    proc_valid = 1'b0;
    proc_last  = 1'b0;
    proc_data  = '0;
    if (state_q == STREAM) begin
      req_ready[grant_q] = proc_ready;
      proc_valid         = req_valid[grant_q];
      proc_last          = req_last[grant_q];
      proc_data          = req_data[32'(grant_q)*DATA_W +: DATA_W];
    end
  end

  assign beat_fire  = proc_valid & proc_ready;
  assign beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 7'd1;

  assign tag_empty = (tag_count_q == '0);
  assign tag_full  = (tag_count_q == CW'(TAG_DEPTH));
  assign head      = tag_mem_q[rd_ptr_q];
  // Full uses the registered count, so a same-cycle pop cannot unblock a grant.
  assign push      = (state_q == IDLE) & win_found & ~tag_full;

  always_comb begin
    rsp_valid = '0;
    if (!tag_empty) rsp_valid[head] = res_valid;
  end

  assign res_ready = ~tag_empty & rsp_ready[head];
  assign pop       = res_valid & res_ready;
  assign rsp_data  = res_data;
  assign busy      = (state_q == STREAM);
  assign err_len   = err_len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_PORTS - 1);
      beat_cnt_q   <= '0;
      err_len_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_count_q  <= '0;
    end else begin
      err_len_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (push) begin
            grant_q    <= win_idx;
            beat_cnt_q <= '0;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_d;
            if (proc_last) begin
              err_len_q    <= (8'(beat_cnt_q) + 8'd1) != 8'(PKT_BEATS);
              last_grant_q <= grant_q;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      tag_count_q <= tag_count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= win_idx;
  end

endmodule

// File: tb/tb_udp_ingress_arbiter.sv
// Directed bench for udp_ingress_arbiter with a queue-based packet/result model
// compared against the DUT on every falling clock edge.
module tb_udp_ingress_arbiter;
  localparam int N     = 4;
  localparam int DW    = 256;
  localparam int PKT   = 63;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [DW-1:0] proc_data;
  logic          proc_valid, proc_last;
  logic          proc_ready = 1'b1;
  logic [DW-1:0] res_data = '0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [DW-1:0] rsp_data;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready = '0;
  logic          busy, err_len;

  udp_ingress_arbiter #(.N_PORTS(N), .DATA_W(DW), .PKT_BEATS(PKT), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .proc_data(proc_data), .proc_valid(proc_valid), .proc_last(proc_last), .proc_ready(proc_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, required %0h", nm, $time, act, exp);
    end
  endtask

  // Upstream sources: each port plays out queued packet lengths.
  int pend [N][$];
  int src_left [N] = '{default: 0};
  int src_beat [N] = '{default: 0};
  int src_pkt  [N] = '{default: 0};
  logic [N-1:0] fire;

  function automatic void drive_src();
    logic [31:0] w;
    for (int p = 0; p < N; p++) begin
      w = {8'(p), 8'(src_pkt[p]), 16'(src_beat[p])};
      req_valid[p] = (src_left[p] > 0);
      req_last[p]  = (src_left[p] == 1);
      req_data[p*DW +: DW] = {(DW/32){w}};
    end
  endfunction

  initial begin
    drive_src();
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (!reset) begin
          src_left[p] = 0;
        end else begin
          if (fire[p]) begin
            src_left[p]--;
            src_beat[p]++;
          end
          if (src_left[p] == 0 && pend[p].size() > 0) begin
            src_left[p] = pend[p].pop_front();
            src_beat[p] = 0;
            src_pkt[p]++;
          end
        end
      end
      drive_src();
    end
  end

  // Model: which port owns the processor, who won last, and the queue of outstanding tags.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;
  bit m_err   = 1'b0;
  int m_tags[$];
  int m_grant[$];

  // Observations of the DUT used by directed checks.
  int cyc = 0;
  bit prev_busy = 1'b0;
  bit need_log = 1'b0;
  int cur_beats = 0;
  int tot_beats = 0;
  int n_err = 0;
  int dut_grant[$];
  int dut_rise[$];

  always @(negedge clk) begin
    logic [N-1:0]  e_rr, e_rv;
    logic          e_pv, e_pl, e_resr, pop, err_nx, found;
    logic [DW-1:0] e_pd;
    cyc++;
    if (!reset) begin
      m_owner = -1; m_last = N - 1; m_beats = 0; m_err = 1'b0;
      m_tags.delete();
    end
    e_rr = '0; e_pv = 1'b0; e_pl = 1'b0; e_pd = '0;
    if (m_owner >= 0) begin
      e_rr[m_owner] = proc_ready;
      e_pv = req_valid[m_owner];
      e_pl = req_last[m_owner];
      e_pd = req_data[m_owner*DW +: DW];
    end
    e_rv = '0; e_resr = 1'b0;
    if (m_tags.size() > 0) begin
      e_rv[m_tags[0]] = res_valid;
      e_resr = rsp_ready[m_tags[0]];
    end
    chk("req_ready",  req_ready,  e_rr);
    chk("proc_valid", proc_valid, e_pv);
    chk("proc_last",  proc_last,  e_pl);
    chk("proc_data",  proc_data,  e_pd);
    chk("rsp_valid",  rsp_valid,  e_rv);
    chk("res_ready",  res_ready,  e_resr);
    chk("rsp_data",   rsp_data,   res_data);
    chk("busy",       busy,       (m_owner >= 0));
    chk("err_len",    err_len,    m_err);

    if (busy && !prev_busy) begin
      dut_rise.push_back(cyc);
      need_log = 1'b1;
      cur_beats = 0;
    end
    if (proc_valid && proc_ready) begin
      cur_beats++;
      tot_beats++;
      if (need_log) begin
        for (int p = 0; p < N; p++) if (req_ready[p]) dut_grant.push_back(p);
        need_log = 1'b0;
      end
    end
    if (err_len) n_err++;
    prev_busy = reset ? busy : 1'b0;

    if (reset) begin
      pop = (m_tags.size() > 0) && res_valid && rsp_ready[m_tags[0]];
      err_nx = 1'b0;
      if (m_owner < 0) begin
        if (req_valid != '0 && m_tags.size() < DEPTH) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            if (!found && req_valid[(m_last + k) % N]) begin
              found = 1'b1;
              m_owner = (m_last + k) % N;
            end
          end
          m_tags.push_back(m_owner);
          m_grant.push_back(m_owner);
          m_beats = 0;
        end
      end else if (req_valid[m_owner] && proc_ready) begin
        if (req_last[m_owner]) begin
          err_nx = (m_beats + 1 != PKT);
          m_last = m_owner;
          m_owner = -1;
        end
        m_beats = (m_beats + 1 > 127) ? 127 : m_beats + 1;
      end
      if (pop) void'(m_tags.pop_front());
      m_err = err_nx;
    end
  end

  function automatic bit quiet();
    bit q = !busy && (req_valid == '0);
    for (int p = 0; p < N; p++) if (pend[p].size() > 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_quiet(input string nm, input int budget);
    int i = 0;
    @(negedge clk);
    while (!quiet() && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(nm, quiet(), 1'b1);
  endtask

  task automatic drain_results(input int cycles);
    @(posedge clk); #1;
    res_valid = 1'b1; rsp_ready = '1;
    repeat (cycles) @(posedge clk);
    #1 res_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gb, rb, mb, bb, i;
    logic [DW-1:0] hold;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst proc_valid", proc_valid, 1'b0);
    chk("rst req_ready", req_ready, 4'b0000);
    chk("rst err_len", err_len, 1'b0);
    @(posedge clk); #1 reset = 1'b1;

    // 1: single 63-beat packet from port 0, then its result
    @(negedge clk);
    bb = tot_beats;
    pend[0].push_back(PKT);
    @(negedge clk);
    chk("t1 busy before grant", busy, 1'b0);
    @(negedge clk);
    chk("t1 busy after grant", busy, 1'b1);
    chk("t1 first beat valid", proc_valid, 1'b1);
    wait_quiet("t1 packet done", 200);
    chk("t1 beats passed", 32'(tot_beats - bb), 32'd63);
    chk("t1 no err_len", 32'(n_err), 32'd0);
    chk("t1 model tag count", 32'(m_tags.size()), 32'd1);
    chk("t1 model tag head", 32'(m_tags[0]), 32'd0);
    @(posedge clk); #1;
    res_valid = 1'b1; res_data = DW'(16'h1234); rsp_ready = '1;
    @(negedge clk);
    chk("t1 rsp_valid", rsp_valid, 4'b0001);
    chk("t1 rsp_data", rsp_data, DW'(16'h1234));
    chk("t1 res_ready", res_ready, 1'b1);
    @(negedge clk);
    chk("t1 fifo empty rsp_valid", rsp_valid, 4'b0000);
    chk("t1 fifo empty res_ready", res_ready, 1'b0);
    @(posedge clk); #1 res_valid = 1'b0;

    // 2: all four ports saturated; round-robin order, one bubble, full FIFO stall
    do_reset();
    @(negedge clk);
    gb = dut_grant.size(); rb = dut_rise.size(); mb = m_grant.size();
    for (int p = 0; p < N; p++) begin
      pend[p].push_back(PKT);
      pend[p].push_back(PKT);
    end
    i = 0;
    while (!((dut_grant.size() - gb >= 4) && !busy) && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("t2 four grants within budget", (i < 400), 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t2 fifth grant blocked", busy, 1'b0);
    end
    drain_results(1);
    @(posedge clk); #1;
    res_valid = 1'b1;
    wait_quiet("t2 all packets done", 800);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 res_valid = 1'b0;
    chk("t2 grant0", 32'(dut_grant[gb+0]), 32'd0);
    chk("t2 grant1", 32'(dut_grant[gb+1]), 32'd1);
    chk("t2 grant2", 32'(dut_grant[gb+2]), 32'd2);
    chk("t2 grant3", 32'(dut_grant[gb+3]), 32'd3);
    chk("t2 grant4", 32'(dut_grant[gb+4]), 32'd0);
    chk("t2 model grant4", 32'(m_grant[mb+4]), 32'd0);
    chk("t2 spacing 0-1", 32'(dut_rise[rb+1] - dut_rise[rb+0]), 32'd64);
    chk("t2 spacing 1-2", 32'(dut_rise[rb+2] - dut_rise[rb+1]), 32'd64);
    chk("t2 spacing 2-3", 32'(dut_rise[rb+3] - dut_rise[rb+2]), 32'd64);

    // 3: port 2 stalled by proc_ready 1,0,0,1 while port 1 requests
    @(negedge clk);
    gb = dut_grant.size();
    pend[2].push_back(PKT);
    i = 0;
    while (dut_grant.size() == gb && i < 20) begin
      @(negedge clk);
      i++;
    end
    repeat (9) @(negedge clk);
    pend[1].push_back(PKT);
    @(posedge clk); #1 proc_ready = 1'b0;
    @(negedge clk);
    chk("t3 stall req_ready", req_ready, 4'b0000);
    chk("t3 stall proc_valid", proc_valid, 1'b1);
    hold = proc_data;
    @(posedge clk); #1 proc_ready = 1'b0;
    @(negedge clk);
    chk("t3 held data", proc_data, hold);
    chk("t3 stall2 req_ready", req_ready, 4'b0000);
    @(posedge clk); #1 proc_ready = 1'b1;
    @(negedge clk);
    chk("t3 resume data", proc_data, hold);
    chk("t3 resume req_ready", req_ready, 4'b0100);
    wait_quiet("t3 packets done", 300);
    chk("t3 first grant", 32'(dut_grant[gb]), 32'd2);
    chk("t3 second grant", 32'(dut_grant[gb+1]), 32'd1);
    drain_results(3);

    // 4: results for {3,1} with port 3 back-pressuring
    @(negedge clk);
    pend[3].push_back(PKT);
    wait_quiet("t4 pkt3 done", 200);
    pend[1].push_back(PKT);
    wait_quiet("t4 pkt1 done", 200);
    chk("t4 model tags size", 32'(m_tags.size()), 32'd2);
    chk("t4 model head", 32'(m_tags[0]), 32'd3);
    @(posedge clk); #1;
    res_valid = 1'b1; res_data = DW'(32'hA5A5_0003); rsp_ready = 4'b0111;
    repeat (4) begin
      @(negedge clk);
      chk("t4 held rsp_valid", rsp_valid, 4'b1000);
      chk("t4 held res_ready", res_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    chk("t4 release res_ready", res_ready, 1'b1);
    chk("t4 release rsp_valid", rsp_valid, 4'b1000);
    @(posedge clk); #1 res_data = DW'(32'h5A5A_0001);
    @(negedge clk);
    chk("t4 port1 rsp_valid", rsp_valid, 4'b0010);
    chk("t4 port1 rsp_data", rsp_data, DW'(32'h5A5A_0001));
    @(posedge clk); #1 res_valid = 1'b0;

    // 5: short packet from port 1 flags a length error
    @(negedge clk);
    pend[1].push_back(10);
    i = 0;
    while (!(proc_valid && proc_last && proc_ready) && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("t5 last beat seen", (i < 100), 1'b1);
    @(negedge clk);
    chk("t5 err_len pulse", err_len, 1'b1);
    chk("t5 back to idle", busy, 1'b0);
    @(negedge clk);
    chk("t5 err_len one cycle", err_len, 1'b0);
    drain_results(2);

    // 6: asynchronous reset mid-packet with two tags outstanding
    @(negedge clk);
    pend[3].push_back(PKT);
    wait_quiet("t6 pkt3 done", 200);
    pend[2].push_back(PKT);
    i = 0;
    while (cur_beats != 30 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("t6 reached beat 30", (i < 100), 1'b1);
    chk("t6 model tags before reset", 32'(m_tags.size()), 32'd2);
    #2 reset = 1'b0; res_valid = 1'b1; rsp_ready = '1;
    #1;
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst proc_valid", proc_valid, 1'b0);
    chk("t6 rst proc_last", proc_last, 1'b0);
    chk("t6 rst proc_data", proc_data, '0);
    chk("t6 rst req_ready", req_ready, 4'b0000);
    chk("t6 rst rsp_valid", rsp_valid, 4'b0000);
    chk("t6 rst res_ready", res_ready, 1'b0);
    chk("t6 rst err_len", err_len, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; res_valid = 1'b0;
    @(negedge clk);
    gb = dut_grant.size();
    pend[0].push_back(5);
    pend[2].push_back(5);
    wait_quiet("t6 after reset done", 100);
    chk("t6 port0 first", 32'(dut_grant[gb]), 32'd0);
    chk("t6 port2 second", 32'(dut_grant[gb+1]), 32'd2);
    drain_results(3);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_ingress_arbiter.md
# udp_ingress_arbiter

Packet-granular round-robin arbiter that shares the single 40 Gbps UDP payload processor (SUM/MAX engine) between N_PORTS ingress streams. It sits directly in front of the processor's In_data/In_valid/In_ready port and forwards one whole packet at a time. It records the granted port of every forwarded packet in an in-order tag FIFO and uses it to route each processor result back to the port that sent the packet.

## Interface
- N_PORTS, 4: number of requesting streams, 2..8.
- DATA_W, 256: beat width.
- PKT_BEATS, 63: expected beats per packet, used for the length check.
- TAG_DEPTH, 4: maximum outstanding packets awaiting a result; power of 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_data  in  N_PORTS*DATA_W  ingress beats; port i occupies bits [i*DATA_W +: DATA_W].
- req_valid  in  N_PORTS  per-port beat valid.
- req_last  in  N_PORTS  per-port last beat of packet.
- req_ready  out  N_PORTS  per-port beat accept.
- proc_data  out  DATA_W  beat to processor.
- proc_valid  out  1  beat valid to processor.
- proc_last  out  1  last beat to processor.
- proc_ready  in  1  processor accepts beat.
- res_data  in  DATA_W  processor result.
- res_valid  in  1  result valid.
- res_ready  out  1  result accept, drives the processor Out_ready.
- rsp_data  out  DATA_W  result to ports; shared bus, equals res_data.
- rsp_valid  out  N_PORTS  one-hot result valid.
- rsp_ready  in  N_PORTS  per-port result accept.
- busy  out  1  packet in flight (STREAM state).
- err_len  out  1  one-cycle pulse when a packet's last beat does not fall on beat PKT_BEATS.

## Operation
**Arbitration FSM**
- States: IDLE, STREAM.
- IDLE:
  - If any req_valid is high and tag_count < TAG_DEPTH, select a winner by round-robin, searching from last_grant+1 modulo N_PORTS upward.
  - Register the winner as grant and push grant into the tag FIFO.
  - Clear beat_cnt and go to STREAM.
  - All req_ready are 0 in IDLE.
- STREAM:
  - proc_data, proc_valid and proc_last are driven from port grant.
  - req_ready[grant] = proc_ready; all other req_ready bits are 0.
  - On each accepted beat (proc_valid & proc_ready), beat_cnt increments. beat_cnt is 7 bits and saturates at 127.
  - On an accepted beat with proc_last:
    - err_len pulses if beat_cnt+1 != PKT_BEATS.
    - last_grant <= grant.
    - Go to IDLE.
- Grant is never revoked mid-packet, whatever the other ports do.
- req_valid of a non-granted port has no effect until that port wins.

**Result routing**
- head = tag FIFO head entry.
- rsp_valid[head] = res_valid & !empty; all other bits are 0.
- res_ready = !empty & rsp_ready[head].
- res_valid & res_ready pops the FIFO.
- A result arriving while the FIFO is empty is stalled (res_ready=0) and is not dropped.

**Tag FIFO**
- Holds clog2(N_PORTS)-bit entries; tag_count ranges 0..TAG_DEPTH.
- Push and pop in the same cycle leave tag_count unchanged.
- Full is evaluated on the registered tag_count, so a pop in the same cycle does not enable a grant while full.

## Timing
- Reset values:
  - state = IDLE, last_grant = N_PORTS-1, so port 0 wins first.
  - Tag FIFO empty, beat_cnt = 0.
  - Outputs: req_ready=0, proc_valid=0, proc_last=0, proc_data=0, res_ready=0, rsp_valid=0, busy=0, err_len=0.
- Grant latency: req_valid seen in IDLE at cycle t gives busy=1 and proc_valid at t+1. The first beat can be accepted at t+1.
- There is one IDLE bubble cycle between consecutive packets. The 63-beat packet cost is therefore at least 64 cycles.
- proc_* and req_ready are combinational from the registered grant and the inputs. There are no registered beat stages, so beat latency is 0.
- rsp_valid and res_ready are combinational from the FIFO head; result latency is 0.
- err_len is registered and is high for exactly the cycle after the offending last beat.
- Reset asserted mid-packet:
  - Immediate return to IDLE and the FIFO is flushed.
  - The partial packet is abandoned; upstream and the processor must also be reset.
- proc_ready low holds the current beat: proc_valid stays high and no beat_cnt change occurs.

## Test plan
1. Port 0 alone sends a 63-beat packet with proc_ready=1. Required: busy rises 1 cycle after req_valid, 63 beats pass unmodified, err_len stays 0, tag FIFO holds {0}. Then res_valid with res_data=0x1234 gives rsp_valid=4'b0001, rsp_data=0x1234, and the FIFO becomes empty.
2. Ports 0..3 all hold req_valid continuously for 5 packets. Required grant order 0,1,2,3,0 with exactly one IDLE cycle between packets. With TAG_DEPTH=4, the 5th grant waits until a result pops.
3. Port 2 streams while proc_ready toggles 1,0,0,1 mid-packet. Required: data is held stable while stalled and req_ready[2] mirrors proc_ready. A port 1 req_valid raised mid-packet does not get a grant until port 2's last beat is accepted.
4. Results for FIFO {3,1} with rsp_ready[3]=0 for 4 cycles. Required: res_ready=0 and rsp_valid=4'b1000 are held. After rsp_ready[3]=1, the next result goes to port 1 (rsp_valid=4'b0010).
5. Port 1 sends a 10-beat packet with last on beat 10. Required: err_len pulses for one cycle and the FSM returns to IDLE normally.
6. Reset is pulled low at beat 30 of a packet with the FIFO holding 2 entries. Required: all outputs go to their reset values asynchronously, tag_count=0, and after release port 0 wins first.
